// File: rtl/circuit2_operand_loader.sv
// circuit2_operand_loader
// Assembles a three-word stream frame (a, b, c) behind a valid/ready handshake.
// The operands are held stable in HOLD until the downstream stage takes them.
// A first-word marker checks frame alignment, and a wrapping counter counts
// the frames handed downstream.
module circuit2_operand_loader #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_first,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic                 frame_err,
    output logic [CNTWIDTH-1:0]  frame_cnt
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATAWIDTH-1:0]  a_q, a_d;
    logic [DATAWIDTH-1:0]  b_q, b_d;
    logic [DATAWIDTH-1:0]  c_q, c_d;
    logic                  err_q, err_d;
    logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
    logic                  accept_s;
    logic                  xfer_s;

    // Handshake flags are plain decodes of the registered state.
    assign in_ready  = (state_q != HOLD);
    assign op_valid  = (state_q == HOLD);
    assign accept_s  = in_valid && in_ready;
    assign xfer_s    = op_valid && op_ready;

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

    // Next-state and operand-load logic; everything holds unless a case updates it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_A: begin
                if (accept_s) begin
                    if (in_first) begin
                        a_d     = in_data;
                        state_d = LOAD_B;
                    end else begin
                        // Misaligned word: drop it and keep waiting for a frame start.
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = LOAD_A;
                end
            end
            LOAD_B: begin
                if (accept_s) begin
                    if (in_first) begin
                        // Resync: the new word starts a fresh frame.
                        a_d     = in_data;
                        err_d   = 1'b1;
                    end else begin
                        b_d     = in_data;
                        state_d = LOAD_C;
                    end
                end else begin
                    state_d = LOAD_B;
                end
            end
            LOAD_C: begin
                if (accept_s) begin
                    if (in_first) begin
                        // Resync: the old b is kept until the next word overwrites it.
                        a_d     = in_data;
                        err_d   = 1'b1;
                        state_d = LOAD_B;
                    end else begin
                        c_d     = in_data;
                        state_d = HOLD;
                    end
                end else begin
                    state_d = LOAD_C;
                end
            end
            HOLD: begin
                if (xfer_s) begin
                    cnt_d   = cnt_q + {{(CNTWIDTH-1){1'b0}}, 1'b1};
                    state_d = LOAD_A;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // State and datapath registers; synchronous reset overrides any accept or transfer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= LOAD_A;
            a_q     <= {DATAWIDTH{1'b0}};
            b_q     <= {DATAWIDTH{1'b0}};
            c_q     <= {DATAWIDTH{1'b0}};
            err_q   <= 1'b0;
            cnt_q   <= {CNTWIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_circuit2_operand_loader.sv
// Scoreboard testbench for circuit2_operand_loader.
// The stimulus pushes the expected operand triples. A negedge monitor then
// compares every HOLD cycle against the front entry and pops it on transfer.
module tb_circuit2_operand_loader;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_first;
    logic          in_ready;
    logic [DW-1:0] a, b, c;
    logic          op_valid;
    logic          op_ready;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    circuit2_operand_loader #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_ready(in_ready), .a(a), .b(b), .c(c),
        .op_valid(op_valid), .op_ready(op_ready), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic [DW-1:0] ec;
    } frame_t;

    frame_t sb_q[$];
    int tests = 0;
    int fails = 0;
    int valid_cycles = 0;
    int ready_low = 0;
    int err_cycles = 0;
    int xfers = 0;

    function automatic void check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: sample away from the active edge and compare the presented operands.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (!in_ready) ready_low++;
            if (frame_err) err_cycles++;
            if (op_valid) begin
                valid_cycles++;
                if (sb_q.size() == 0) begin
                    check("unexpected_op_valid", 1, 0);
                end else begin
                    check("op_a", a, sb_q[0].ea);
                    check("op_b", b, sb_q[0].eb);
                    check("op_c", c, sb_q[0].ec);
                    if (op_ready) begin
                        void'(sb_q.pop_front());
                        xfers++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic f);
        int n;
        in_data  = d;
        in_first = f;
        in_valid = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge Clk);
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic frame(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        sb_q.push_back({x, y, z});
        send(x, 1'b1);
        send(y, 1'b0);
        send(z, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        idle(2);
        Rst = 1'b0;
    endtask

    int v0, r0, e0, x0;

    initial begin
        Rst = 1'b1; in_data = '0; in_valid = 1'b0; in_first = 1'b0; op_ready = 1'b1;
        idle(2);
        @(negedge Clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_op_valid", op_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_c", c, 0);
        check("rst_err", frame_err, 0);
        check("rst_cnt", frame_cnt, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Basic frame with op_ready always high
        v0 = valid_cycles; r0 = ready_low;
        frame(32'd5, 32'd3, 32'd7);
        idle(3);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_ready_low", ready_low - r0, 1);
        check("t1_cnt", frame_cnt, 1);

        // Held frame: op_ready low for 10 cycles
        op_ready = 1'b0;
        v0 = valid_cycles; r0 = ready_low; x0 = xfers;
        frame(32'd5, 32'd3, 32'd7);
        idle(10);
        op_ready = 1'b1;
        idle(3);
        check("t2_valid_cycles", valid_cycles - v0, 11);
        check("t2_ready_low", ready_low - r0, 11);
        check("t2_xfers", xfers - x0, 1);
        check("t2_cnt", frame_cnt, 2);

        // Misaligned word in LOAD_A is dropped
        e0 = err_cycles;
        send(32'd9, 1'b0);
        frame(32'd5, 32'd3, 32'd7);
        idle(3);
        check("t3_err", err_cycles - e0, 1);
        check("t3_cnt", frame_cnt, 3);

        // Resync in LOAD_C
        e0 = err_cycles;
        sb_q.push_back({32'd4, 32'd6, 32'd8});
        send(32'd1, 1'b1);
        send(32'd2, 1'b0);
        send(32'd4, 1'b1);
        send(32'd6, 1'b0);
        send(32'd8, 1'b0);
        idle(3);
        check("t4_err", err_cycles - e0, 1);
        check("t4_cnt", frame_cnt, 4);

        // Counter wrap: 15 frames reach all-ones, one more wraps to 0
        do_reset();
        check("t5_cnt_after_reset", frame_cnt, 0);
        for (int i = 0; i < 15; i++) begin
            frame(32'h100 + i, 32'h200 + i, 32'h300 + i);
        end
        idle(2);
        check("t5_cnt_allones", frame_cnt, 15);
        frame(32'hA, 32'hB, 32'hC);
        idle(2);
        check("t5_cnt_wrap", frame_cnt, 0);

        // Reset in HOLD together with op_ready wins over the transfer
        op_ready = 1'b0;
        frame(32'd11, 32'd22, 32'd33);
        idle(1);
        check("t6_in_hold", op_valid, 1);
        Rst = 1'b1;
        op_ready = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        sb_q.delete();
        check("t6_op_valid", op_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_a", a, 0);
        check("t6_b", b, 0);
        check("t6_c", c, 0);
        check("t6_err", frame_err, 0);
        check("t6_cnt", frame_cnt, 0);

        idle(2);
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
